// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: interrupt register map, controller FSM states,
// default handler vector layout and the vector address helper.
// Optional build macro used by irq_controller: IRQ_LEVEL_MODE_EN.
package cpu_pkg;

    // Interrupt controller register map (cfg_addr)
    localparam logic [1:0] IRQ_REG_MASK    = 2'd0;
    localparam logic [1:0] IRQ_REG_CTRL    = 2'd1;
    localparam logic [1:0] IRQ_REG_PENDING = 2'd2;
    localparam logic [1:0] IRQ_REG_SWTRIG  = 2'd3;

    // Default handler table layout
    localparam logic [15:0] IRQ_VECTOR_BASE_DEFAULT   = 16'hFF00;
    localparam logic [15:0] IRQ_VECTOR_STRIDE_DEFAULT = 16'h0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } irq_ctl_state;

    // Handler address of a source; arithmetic wraps at 16 bits.
    function automatic logic [15:0] irq_vector_calc(
        input logic [15:0] base,
        input logic [15:0] stride,
        input logic [3:0]  id
    );
        logic [15:0] offset;
        offset = stride * {12'd0, id};
        return base + offset;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
// Purely combinational; valid_o is low when nothing is eligible (index then 0).
// N may be 1..16 so the index always fits in 4 bits.
module irq_priority_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] eligible_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);

    // Scan from the top down so the last hit (lowest index) is kept
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt aggregator: latches source events, masks/gates them, requests the
// lowest pending index from the control FSM with a stable handler vector.
// Default build is edge-triggered; define IRQ_LEVEL_MODE_EN for level sources.
module irq_controller
    import cpu_pkg::*;
#(
    parameter int          NUM_SOURCES    = 8,
    parameter logic [15:0] VECTOR_BASE    = IRQ_VECTOR_BASE_DEFAULT,
    parameter logic [15:0] VECTOR_STRIDE  = IRQ_VECTOR_STRIDE_DEFAULT,
    parameter int          HOLDOFF_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   reset_irq,
    input  logic                   cfg_we,
    input  logic                   cfg_re,
    input  logic [1:0]             cfg_addr,
    input  logic [15:0]            cfg_wdata,
    output logic [15:0]            cfg_rdata,
    output logic                   irq,
    output logic [15:0]            irq_vector,
    output logic [3:0]             irq_id
);

    localparam int          N           = NUM_SOURCES;
    localparam logic [3:0]  HOLDOFF_INI = 4'(HOLDOFF_CYCLES);

    typedef logic [N-1:0] src_vec_t;

    // Architectural state
    irq_ctl_state state_q, state_d;
    src_vec_t     mask_q, mask_d;
    logic         gen_q, gen_d;
    src_vec_t     pend_q, pend_d;     // edge mode: all pending; level mode: software bits only
    logic [3:0]   id_q, id_d;
    logic [15:0]  vec_q, vec_d;
    logic         irq_q, irq_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  rdata_q, rdata_d;

    // Decoded strobes and derived vectors
    src_vec_t     wdata_n;
    logic         wr_mask, wr_ctrl, wr_w1c, wr_swtrig;
    logic         ack;
    src_vec_t     ack_vec;
    src_vec_t     hw_set;
    src_vec_t     pending;
    src_vec_t     eligible;
    logic         win_vld;
    logic [3:0]   win_idx;
    logic         unused_wdata;

    assign wdata_n      = cfg_wdata[N-1:0];
    assign unused_wdata = ^cfg_wdata;

    assign wr_mask   = cfg_we && (cfg_addr == IRQ_REG_MASK);
    assign wr_ctrl   = cfg_we && (cfg_addr == IRQ_REG_CTRL);
    assign wr_w1c    = cfg_we && (cfg_addr == IRQ_REG_PENDING);
    assign wr_swtrig = cfg_we && (cfg_addr == IRQ_REG_SWTRIG);

    // Acknowledge only counts while a request is outstanding
    assign ack = reset_irq && (state_q == REQ);

`ifdef IRQ_LEVEL_MODE_EN
    // Level sources feed pending directly; only software-set bits are stored
    assign hw_set  = '0;
    assign pending = irq_src | pend_q;
`else
    src_vec_t src_q;

    // Edge history: previous sample of each source line
    always_ff @(posedge clock) begin
        if (reset) src_q <= '0;
        else       src_q <= irq_src;
    end

    assign hw_set  = irq_src & ~src_q;
    assign pending = pend_q;
`endif

    assign eligible = gen_q ? (pending & mask_q) : '0;

    irq_priority_enc #(
        .N (N)
    ) u_prio (
        .eligible_i (eligible),
        .valid_o    (win_vld),
        .idx_o      (win_idx)
    );

    // One-hot of the latched source, used to retire it on acknowledge
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < N; i++) begin
            ack_vec[i] = ack && (id_q == 4'(i));
        end
    end

    // Pending update: sets (edge / SWTRIG) beat clears (W1C / ack) on the same bit
    always_comb begin
        src_vec_t set_v;
        src_vec_t clr_v;
        set_v  = hw_set | (wr_swtrig ? wdata_n : '0);
        clr_v  = (wr_w1c ? wdata_n : '0) | ack_vec;
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    // Config register next state and registered read-back
    always_comb begin
        mask_d  = wr_mask ? wdata_n : mask_q;
        gen_d   = wr_ctrl ? cfg_wdata[0] : gen_q;
        rdata_d = rdata_q;
        if (cfg_re) begin
            case (cfg_addr)
                IRQ_REG_MASK:    rdata_d = 16'(mask_q);
                IRQ_REG_CTRL:    rdata_d = {15'd0, gen_q};
                IRQ_REG_PENDING: rdata_d = 16'(pending);
                default:         rdata_d = 16'd0;
            endcase
        end
    end

    // Config and pending registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= '0;
            gen_q   <= 1'b0;
            pend_q  <= '0;
            rdata_q <= 16'd0;
        end else begin
            mask_q  <= mask_d;
            gen_q   <= gen_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: select in IDLE, wait for ack in REQ, count out HOLDOFF
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld)        state_d = REQ;
            REQ:     if (reset_irq)      state_d = HOLDOFF;
            HOLDOFF: if (cnt_q <= 4'd1)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // FSM outputs: winner latched only in IDLE, irq follows REQ by one cycle
    always_comb begin
        id_d  = id_q;
        vec_d = vec_q;
        cnt_d = cnt_q;
        irq_d = (state_q == REQ) && !reset_irq;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d  = win_idx;
                    vec_d = irq_vector_calc(VECTOR_BASE, VECTOR_STRIDE, win_idx);
                end
            end
            REQ: begin
                if (reset_irq) cnt_d = HOLDOFF_INI;
            end
            HOLDOFF: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    // FSM output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q  <= 4'd0;
            vec_q <= 16'd0;
            cnt_q <= 4'd0;
            irq_q <= 1'b0;
        end else begin
            id_q  <= id_d;
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    assign irq        = irq_q;
    assign irq_vector = vec_q;
    assign irq_id     = id_q;
    assign cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (8 sources, default vector layout).
// Inputs change and outputs are sampled on the falling clock edge.
// Level-mode expectations are selected with IRQ_LEVEL_MODE_EN.
module tb_irq_controller;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq_src = 8'h00;
    logic        reset_irq = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'h0000;
    logic [15:0] cfg_rdata;
    logic        irq;
    logic [15:0] irq_vector;
    logic [3:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    irq_controller #(
        .NUM_SOURCES    (8),
        .VECTOR_BASE    (16'hFF00),
        .VECTOR_STRIDE  (16'h0010),
        .HOLDOFF_CYCLES (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .reset_irq  (reset_irq),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_id     (irq_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0000;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [15:0] d);
        cfg_re   = 1'b1;
        cfg_addr = a;
        tick();
        cfg_re   = 1'b0;
        d        = cfg_rdata;
    endtask

    task automatic ack_pulse();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    // Bounded wait for irq; seen stays 0 if the budget runs out
    task automatic wait_irq(input int max_cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (irq !== 1'b0) c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        seen;
        int          highs;

        @(negedge clock);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check_eq("reset_irq_out", irq, 0);
        check_eq("reset_vector", irq_vector, 0);
        check_eq("reset_id", irq_id, 0);
        check_eq("reset_rdata", cfg_rdata, 0);

        // ---- single enabled source, edge on irq_src[2]
        cfg_wr(IRQ_REG_MASK, 16'h0004);
        cfg_wr(IRQ_REG_CTRL, 16'h0001);
        irq_src = 8'h04;
        tick();
        check_eq("src2_irq_c1", irq, 0);
        tick();
        check_eq("src2_irq_c2", irq, 0);
        check_eq("src2_id_latched", irq_id, 2);
        check_eq("src2_vector_latched", irq_vector, 16'hFF20);
        tick();
        check_eq("src2_irq_high", irq, 1);
        ack_pulse();
        check_eq("src2_irq_drop", irq, 0);
        count_high(4, highs);
        check_eq("src2_holdoff_low", highs, 0);
`ifdef IRQ_LEVEL_MODE_EN
        wait_irq(10, seen);
        check_eq("src2_level_rerequest", seen, 1);
        check_eq("src2_level_id", irq_id, 2);
        irq_src = 8'h00;
        ack_pulse();
`else
        count_high(10, highs);
        check_eq("src2_edge_no_rerequest", highs, 0);
        irq_src = 8'h00;
`endif
        idle(8);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("src2_pending_cleared", rd, 16'h0000);

        // ---- priority: sources 5 and 1 rise together
        cfg_wr(IRQ_REG_MASK, 16'h00FF);
        irq_src = 8'h22;
        wait_irq(10, seen);
        check_eq("prio_first_seen", seen, 1);
        check_eq("prio_first_id", irq_id, 1);
        check_eq("prio_first_vector", irq_vector, 16'hFF10);
        irq_src = 8'h20;
        ack_pulse();
        check_eq("prio_first_drop", irq, 0);
        wait_irq(15, seen);
        check_eq("prio_second_seen", seen, 1);
        check_eq("prio_second_id", irq_id, 5);
        check_eq("prio_second_vector", irq_vector, 16'hFF50);
        irq_src = 8'h00;
        ack_pulse();
        idle(8);

        // ---- stability: source 0 fires while source 3 is being requested
        irq_src = 8'h08;
        wait_irq(10, seen);
        check_eq("stab_seen", seen, 1);
        check_eq("stab_id", irq_id, 3);
        irq_src = 8'h09;
        idle(3);
        check_eq("stab_vector_held", irq_vector, 16'hFF30);
        check_eq("stab_id_held", irq_id, 3);
        check_eq("stab_irq_held", irq, 1);
        irq_src = 8'h01;
        ack_pulse();
        wait_irq(15, seen);
        check_eq("stab_next_seen", seen, 1);
        check_eq("stab_next_id", irq_id, 0);
        check_eq("stab_next_vector", irq_vector, 16'hFF00);
        irq_src = 8'h00;
        ack_pulse();
        idle(8);

        // ---- global enable gating
        cfg_wr(IRQ_REG_CTRL, 16'h0000);
        cfg_wr(IRQ_REG_MASK, 16'hFFFF);
        cfg_wr(IRQ_REG_SWTRIG, 16'h0001);
        count_high(6, highs);
        check_eq("gen0_no_irq", highs, 0);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("gen0_pending", rd, 16'h0001);
        cfg_rd(IRQ_REG_MASK, rd);
        check_eq("mask_readback_width", rd, 16'h00FF);
        cfg_wr(IRQ_REG_CTRL, 16'hFFFF);
        check_eq("gen1_irq_c1", irq, 0);
        tick();
        check_eq("gen1_irq_c2", irq, 0);
        tick();
        check_eq("gen1_irq_high", irq, 1);
        check_eq("gen1_id", irq_id, 0);
        cfg_rd(IRQ_REG_CTRL, rd);
        check_eq("ctrl_readback", rd, 16'h0001);
        ack_pulse();
        idle(8);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("gen1_pending_after_ack", rd, 16'h0000);

        // ---- masked source stays pending and is never requested
        cfg_wr(IRQ_REG_MASK, 16'h00FE);
        cfg_wr(IRQ_REG_SWTRIG, 16'h0001);
        count_high(10, highs);
        check_eq("masked_no_irq", highs, 0);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("masked_still_pending", rd, 16'h0001);
        cfg_wr(IRQ_REG_PENDING, 16'h0001);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("w1c_clears", rd, 16'h0000);

        // ---- W1C colliding with a source edge on bit 4
        cfg_wr(IRQ_REG_MASK, 16'h00EF);
        irq_src   = 8'h10;
        cfg_we    = 1'b1;
        cfg_addr  = IRQ_REG_PENDING;
        cfg_wdata = 16'h0010;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0000;
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("collision_set_wins", rd, 16'h0010);
        cfg_wr(IRQ_REG_PENDING, 16'h0010);
        cfg_rd(IRQ_REG_PENDING, rd);
`ifdef IRQ_LEVEL_MODE_EN
        check_eq("w1c_level_line_high", rd, 16'h0010);
`else
        check_eq("w1c_edge_cleared", rd, 16'h0000);
`endif
        irq_src = 8'h00;
        cfg_wr(IRQ_REG_PENDING, 16'h0010);
        cfg_wr(IRQ_REG_MASK, 16'h00FF);

        // ---- software trigger of source 3
        cfg_wr(IRQ_REG_SWTRIG, 16'h0008);
        wait_irq(10, seen);
        check_eq("swtrig_seen", seen, 1);
        check_eq("swtrig_id", irq_id, 3);
        check_eq("swtrig_vector", irq_vector, 16'hFF30);
        cfg_rd(IRQ_REG_SWTRIG, rd);
        check_eq("swtrig_reads_zero", rd, 16'h0000);

        // ---- reset while requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midreset_irq", irq, 0);
        check_eq("midreset_vector", irq_vector, 0);
        check_eq("midreset_id", irq_id, 0);
        check_eq("midreset_rdata", cfg_rdata, 0);
        cfg_rd(IRQ_REG_MASK, rd);
        check_eq("midreset_mask", rd, 16'h0000);
        cfg_rd(IRQ_REG_CTRL, rd);
        check_eq("midreset_ctrl", rd, 16'h0000);
        cfg_rd(IRQ_REG_PENDING, rd);
        check_eq("midreset_pending", rd, 16'h0000);
        ack_pulse();
        count_high(4, highs);
        check_eq("spurious_ack_irq", highs, 0);
        check_eq("spurious_ack_id", irq_id, 0);
        cfg_wr(IRQ_REG_MASK, 16'h00FF);
        cfg_wr(IRQ_REG_CTRL, 16'h0001);
        count_high(6, highs);
        check_eq("midreset_events_lost", highs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
